rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
Shares the single-port unified memory between the instruction-fetch requester (I) and the load/store requester (D) of the multicycle core. Each requester gets a valid/ready request channel and a one-cycle response pulse. The block sequences every memory access: it accepts, issues and waits out the memory read latency, then returns read data. It sits between the core's fetch/LSU logic and the memory's mem_addr/mem_rd_data/mem_wr_data/mem_wr_ena port.

Parameters:
MEM_LATENCY, 1, cycles from mem_addr valid to mem_rd_data valid (legal 1..4)
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (asserted when 0)
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  ADDR_W  fetch address
i_rsp_valid  out  1  fetch response pulse
i_rsp_data  out  32  fetch read data
i_rsp_err  out  1  fetch misaligned error, qualified by i_rsp_valid
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_req_addr  in  ADDR_W  data address
d_req_wr_ena  in  1  1 = store, 0 = load
d_req_wr_data  in  32  store data
d_rsp_valid  out  1  data response pulse (load data or store ack)
d_rsp_data  out  32  load data
d_rsp_err  out  1  data misaligned error, qualified by d_rsp_valid
mem_addr  out  ADDR_W  memory address
mem_wr_data  out  32  memory write data
mem_wr_ena  out  1  memory write strobe
mem_rd_data  in  32  memory read data

Behaviour:
- Reset (rst=0, async): state=S_IDLE; all outputs 0; lat_cnt=0; last_grant=I. mem_wr_ena drops immediately, mid-access included. An in-flight access is dropped with no response.
- States: S_IDLE, S_ISSUE, S_WAIT, S_RESP.
- Accept window: S_IDLE or S_RESP. Ready is combinational: x_req_ready = window and x_req_valid and grant==x. At most one ready high per cycle.
- Handshake: a request transfers when valid and ready are both high. The arbiter captures addr, wr_ena and wr_data into internal registers. Requesters hold their fields stable until ready.
- Arbitration, default: fixed priority, D over I.
- Misaligned request (addr[1:0]!=0): accepted, never issued to memory. Next state is S_RESP with x_rsp_err=1 and x_rsp_data=0.
- Aligned request: next state is S_ISSUE.
- S_ISSUE:
  - mem_addr = captured address; mem_wr_data = captured data; mem_wr_ena = captured wr_ena (I is always a read).
  - Write: next state S_RESP.
  - Read: lat_cnt loads MEM_LATENCY-1. If MEM_LATENCY==1, capture mem_rd_data and go to S_RESP; otherwise go to S_WAIT.
- S_WAIT: mem_addr held; mem_wr_ena=0; lat_cnt decrements. When lat_cnt==1, capture mem_rd_data and go to S_RESP.
- S_RESP:
  - Exactly one cycle of x_rsp_valid=1 for the granted requester. rsp_data/rsp_err are registered and stable this cycle.
  - Store ack: rsp_data=0.
  - If a new request is accepted, next state is S_ISSUE (or S_RESP if misaligned); otherwise S_IDLE.
- Latency: aligned read accepted at cycle 0 gets rsp_valid at cycle MEM_LATENCY+1. Write accepted at cycle 0 gets ack at cycle 2.
- Outside S_ISSUE/S_WAIT: mem_addr=0, mem_wr_data=0, mem_wr_ena=0.
- Simultaneous events: a valid arriving in S_ISSUE or S_WAIT waits, because ready stays low. Response and new accept in the same S_RESP cycle are legal.
- Illegal state encoding: return to S_IDLE.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: on contention, grant goes to the requester not in last_grant. last_grant updates on every accept; with no contention, whichever is valid wins.
- Undefined: fixed D-over-I priority; last_grant is unused and removed.

Decomposition:
- Shared package (alongside rv32i_defines):
  - arb_state_t enum (S_IDLE, S_ISSUE, S_WAIT, S_RESP);
  - requester_t enum (REQ_I, REQ_D);
  - MEM_LATENCY_MAX=4 constant.
- One natural sub-module: rv32i_arb_grant, the combinational/registered grant picker holding last_grant. It takes i_valid, d_valid and window, and outputs grant. This isolates the ARB_ROUND_ROBIN_EN variant.

Test Plan:
1. MEM_LATENCY=1; I read 0x0000_0010 alone, memory returns 0x0000_0013 -> i_req_ready at cycle 0, mem_addr=0x10 at cycle 1, i_rsp_valid with data 0x13 at cycle 2, d_* silent.
2. I and D valid in the same cycle (D load 0x100) -> default: D granted first, I granted in D's S_RESP cycle. With ARB_ROUND_ROBIN_EN and last_grant=D: I first.
3. D store addr 0x200 data 0xDEADBEEF -> mem_wr_ena=1 for exactly one cycle with mem_addr=0x200; d_rsp_valid with d_rsp_data=0 one cycle later.
4. MEM_LATENCY=3 D load -> mem_addr held 3 cycles; d_rsp_valid at cycle 4; a new I valid during S_WAIT sees i_req_ready=0 until S_RESP.
5. D load 0x102 (misaligned) -> no mem access (mem_addr=0, mem_wr_ena=0); d_rsp_valid and d_rsp_err=1 at cycle 1.
6. rst asserted in S_ISSUE of a store -> mem_wr_ena falls before the next clk edge; after release: S_IDLE, no stale rsp_valid.

Source files
------------

// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package rv32i_mem_arbiter_pkg;

    localparam int unsigned MEM_LATENCY_MAX = 4;
    localparam int unsigned LAT_W           = $clog2(MEM_LATENCY_MAX + 1);
    localparam int unsigned DATA_W          = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

endpackage

// File: rtl/rv32i_arb_grant.sv
// Grant picker for the I/D requesters.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise fixed D-over-I priority.
module rv32i_arb_grant
    import rv32i_mem_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       window,
`endif
    input  logic       i_valid,
    input  logic       d_valid,
    output requester_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
    requester_t r_last_grant;

    always_comb begin
        grant = d_valid ? REQ_D : REQ_I;
        if (i_valid && d_valid) begin
            grant = (r_last_grant == REQ_I) ? REQ_D : REQ_I;
        end
    end

    // Remember the winner of every accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= REQ_I;
        end else if (window && (i_valid || d_valid)) begin
            r_last_grant <= grant;
        end
    end
`else
    logic w_unused_i_valid;
    assign w_unused_i_valid = i_valid;
    assign grant = d_valid ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D).
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration in rv32i_arb_grant.
module rv32i_mem_arbiter
    import rv32i_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    output logic [31:0]       i_rsp_data,
    output logic              i_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_wr_ena,
    input  logic [31:0]       d_req_wr_data,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic              mem_wr_ena,
    input  logic [31:0]       mem_rd_data
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr_ena;
        logic [DATA_W-1:0] wr_data;
    } req_t;

    arb_state_t        r_state, w_state_nxt;
    requester_t        r_owner, w_owner_nxt, w_grant;
    req_t              r_req, w_req_nxt, w_req_in;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_err, w_err_nxt;
    logic [LAT_W-1:0]  r_lat_cnt, w_lat_nxt;
    logic              w_window, w_accept, w_mem_live, w_i_rsp, w_d_rsp;

    rv32i_arb_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
        .clk     (clk),
        .rst     (rst),
        .window  (w_window),
`endif
        .i_valid (i_req_valid),
        .d_valid (d_req_valid),
        .grant   (w_grant)
    );

    assign w_window    = (r_state == S_IDLE) || (r_state == S_RESP);
    assign i_req_ready = w_window && i_req_valid && (w_grant == REQ_I);
    assign d_req_ready = w_window && d_req_valid && (w_grant == REQ_D);
    assign w_accept    = i_req_ready || d_req_ready;

    // Fetches are always reads with no write data.
    always_comb begin
        w_req_in = '0;
        if (w_grant == REQ_D) begin
            w_req_in.addr    = d_req_addr;
            w_req_in.wr_ena  = d_req_wr_ena;
            w_req_in.wr_data = d_req_wr_data;
        end else begin
            w_req_in.addr    = i_req_addr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_req_nxt   = r_req;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_lat_nxt   = r_lat_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    w_owner_nxt = w_grant;
                    w_req_nxt   = w_req_in;
                    w_rdata_nxt = '0;
                    if (w_req_in.addr[1:0] != 2'b00) begin
                        w_state_nxt = S_RESP;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_err_nxt   = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                if (r_req.wr_ena) begin
                    w_state_nxt = S_RESP;
                    w_rdata_nxt = '0;
                end else begin
                    w_lat_nxt = LAT_W'(MEM_LATENCY - 32'd1);
                    if (MEM_LATENCY == 32'd1) begin
                        w_rdata_nxt = mem_rd_data;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_lat_nxt = r_lat_cnt - LAT_W'(1);
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_rdata_nxt = mem_rd_data;
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_mem_live = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);
    assign w_i_rsp    = (w_state_nxt == S_RESP) && (w_owner_nxt == REQ_I);
    assign w_d_rsp    = (w_state_nxt == S_RESP) && (w_owner_nxt == REQ_D);

    // Outputs are registered from next-state values so they align with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= REQ_I;
            r_req       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_lat_cnt   <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr_ena  <= 1'b0;
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= '0;
            i_rsp_err   <= 1'b0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= '0;
            d_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_req       <= w_req_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
            r_lat_cnt   <= w_lat_nxt;
            mem_addr    <= w_mem_live ? w_req_nxt.addr : '0;
            mem_wr_data <= w_mem_live ? w_req_nxt.wr_data : '0;
            mem_wr_ena  <= (w_state_nxt == S_ISSUE) && w_req_nxt.wr_ena;
            i_rsp_valid <= w_i_rsp;
            i_rsp_data  <= w_i_rsp ? w_rdata_nxt : '0;
            i_rsp_err   <= w_i_rsp && w_err_nxt;
            d_rsp_valid <= w_d_rsp;
            d_rsp_data  <= w_d_rsp ? w_rdata_nxt : '0;
            d_rsp_err   <= w_d_rsp && w_err_nxt;
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: one instance at latency 1, one at latency 3.
module tb_rv32i_mem_arbiter;

    logic        clk, rst, sel3;
    logic        i_v, d_v, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;

    logic        i_req_ready_1, i_rsp_valid_1, i_rsp_err_1;
    logic        d_req_ready_1, d_rsp_valid_1, d_rsp_err_1, mem_wr_ena_1;
    logic [31:0] i_rsp_data_1, d_rsp_data_1, mem_addr_1, mem_wr_data_1, mem_rd_data_1;

    logic        i_req_ready_3, i_rsp_valid_3, i_rsp_err_3;
    logic        d_req_ready_3, d_rsp_valid_3, d_rsp_err_3, mem_wr_ena_3;
    logic [31:0] i_rsp_data_3, d_rsp_data_3, mem_addr_3, mem_wr_data_3, mem_rd_data_3;

    int n_checks = 0;
    int n_errors = 0;
    int age3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: data = addr + 3; the latency-3 one only returns it after the address is held 2 cycles.
    assign mem_rd_data_1 = mem_addr_1 + 32'd3;
    always @(posedge clk or negedge rst) begin
        if (!rst) age3 <= 0;
        else      age3 <= (mem_addr_3 != 32'd0) ? age3 + 1 : 0;
    end
    assign mem_rd_data_3 = (age3 >= 2) ? mem_addr_3 + 32'd3 : 32'hBAD0_0000;

    rv32i_mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req_valid(i_v & ~sel3), .i_req_ready(i_req_ready_1), .i_req_addr(i_addr),
        .i_rsp_valid(i_rsp_valid_1), .i_rsp_data(i_rsp_data_1), .i_rsp_err(i_rsp_err_1),
        .d_req_valid(d_v & ~sel3), .d_req_ready(d_req_ready_1), .d_req_addr(d_addr),
        .d_req_wr_ena(d_wr), .d_req_wr_data(d_wdata),
        .d_rsp_valid(d_rsp_valid_1), .d_rsp_data(d_rsp_data_1), .d_rsp_err(d_rsp_err_1),
        .mem_addr(mem_addr_1), .mem_wr_data(mem_wr_data_1), .mem_wr_ena(mem_wr_ena_1),
        .mem_rd_data(mem_rd_data_1)
    );

    rv32i_mem_arbiter #(.MEM_LATENCY(3), .ADDR_W(32)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req_valid(i_v & sel3), .i_req_ready(i_req_ready_3), .i_req_addr(i_addr),
        .i_rsp_valid(i_rsp_valid_3), .i_rsp_data(i_rsp_data_3), .i_rsp_err(i_rsp_err_3),
        .d_req_valid(d_v & sel3), .d_req_ready(d_req_ready_3), .d_req_addr(d_addr),
        .d_req_wr_ena(d_wr), .d_req_wr_data(d_wdata),
        .d_rsp_valid(d_rsp_valid_3), .d_rsp_data(d_rsp_data_3), .d_rsp_err(d_rsp_err_3),
        .mem_addr(mem_addr_3), .mem_wr_data(mem_wr_data_3), .mem_wr_ena(mem_wr_ena_3),
        .mem_rd_data(mem_rd_data_3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; sel3 = 1'b0;
        i_v = 1'b0; i_addr = '0; d_v = 1'b0; d_addr = '0; d_wr = 1'b0; d_wdata = '0;
        repeat (2) tick();
        check("rst_i_rsp_valid", 32'(i_rsp_valid_1), 32'd0);
        check("rst_mem_addr",    mem_addr_1,         32'd0);
        check("rst_mem_wr_ena",  32'(mem_wr_ena_1),  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Lone fetch, latency 1
        tick(); i_v = 1'b1; i_addr = 32'h10; #1;
        check("t1_i_ready", 32'(i_req_ready_1), 32'd1);
        check("t1_d_ready", 32'(d_req_ready_1), 32'd0);
        tick(); i_v = 1'b0; #1;
        check("t1_mem_addr",  mem_addr_1,          32'h10);
        check("t1_rsp_early", 32'(i_rsp_valid_1),  32'd0);
        tick();
        check("t1_i_rsp_valid", 32'(i_rsp_valid_1), 32'd1);
        check("t1_i_rsp_data",  i_rsp_data_1,        32'h13);
        check("t1_i_rsp_err",   32'(i_rsp_err_1),    32'd0);
        check("t1_d_silent",    32'(d_rsp_valid_1),  32'd0);
        tick();
        check("t1_rsp_once", 32'(i_rsp_valid_1), 32'd0);

        // Contention: D first, I accepted in D's response cycle
        tick(); d_v = 1'b1; d_addr = 32'h100; d_wr = 1'b0; i_v = 1'b1; i_addr = 32'h10; #1;
        check("t2_d_ready", 32'(d_req_ready_1), 32'd1);
        check("t2_i_ready", 32'(i_req_ready_1), 32'd0);
        tick(); d_v = 1'b0; #1;
        check("t2_i_ready_issue", 32'(i_req_ready_1), 32'd0);
        check("t2_mem_addr_d",    mem_addr_1,         32'h100);
        tick();
        check("t2_d_rsp_valid",  32'(d_rsp_valid_1), 32'd1);
        check("t2_d_rsp_data",   d_rsp_data_1,        32'h103);
        check("t2_i_ready_resp", 32'(i_req_ready_1), 32'd1);
        tick(); i_v = 1'b0; #1;
        check("t2_mem_addr_i", mem_addr_1,         32'h10);
        check("t2_d_rsp_once", 32'(d_rsp_valid_1), 32'd0);
        tick();
        check("t2_i_rsp_valid", 32'(i_rsp_valid_1), 32'd1);
        check("t2_i_rsp_data",  i_rsp_data_1,        32'h13);

        // Store
        tick(); d_v = 1'b1; d_addr = 32'h200; d_wr = 1'b1; d_wdata = 32'hDEAD_BEEF; #1;
        check("t3_d_ready", 32'(d_req_ready_1), 32'd1);
        tick(); d_v = 1'b0; d_wr = 1'b0; #1;
        check("t3_wr_ena",  32'(mem_wr_ena_1), 32'd1);
        check("t3_addr",    mem_addr_1,         32'h200);
        check("t3_wr_data", mem_wr_data_1,      32'hDEAD_BEEF);
        check("t3_no_ack",  32'(d_rsp_valid_1), 32'd0);
        tick();
        check("t3_wr_ena_off", 32'(mem_wr_ena_1), 32'd0);
        check("t3_ack",        32'(d_rsp_valid_1), 32'd1);
        check("t3_ack_data",   d_rsp_data_1,        32'd0);
        check("t3_ack_err",    32'(d_rsp_err_1),    32'd0);

        // Misaligned load
        tick(); d_v = 1'b1; d_addr = 32'h102; #1;
        check("t5_d_ready", 32'(d_req_ready_1), 32'd1);
        tick(); d_v = 1'b0; #1;
        check("t5_mem_addr",  mem_addr_1,          32'd0);
        check("t5_wr_ena",    32'(mem_wr_ena_1),   32'd0);
        check("t5_rsp_valid", 32'(d_rsp_valid_1),  32'd1);
        check("t5_rsp_err",   32'(d_rsp_err_1),    32'd1);
        check("t5_rsp_data",  d_rsp_data_1,         32'd0);

        // Reset during a store issue
        tick(); d_v = 1'b1; d_wr = 1'b1; d_addr = 32'h204; d_wdata = 32'h1234; #1;
        tick(); d_v = 1'b0; d_wr = 1'b0; #1;
        check("t6_wr_ena_pre", 32'(mem_wr_ena_1), 32'd1);
        #1 rst = 1'b0; #1;
        check("t6_wr_ena_async", 32'(mem_wr_ena_1), 32'd0);
        check("t6_addr_async",   mem_addr_1,         32'd0);
        tick(); rst = 1'b1;
        tick();
        check("t6_no_stale_rsp", 32'(d_rsp_valid_1), 32'd0);
        check("t6_wr_ena_idle",  32'(mem_wr_ena_1),  32'd0);
        tick();
        check("t6_no_stale_rsp2", 32'(d_rsp_valid_1), 32'd0);

        // Latency-3 load with a fetch arriving during the wait
        tick(); sel3 = 1'b1; d_v = 1'b1; d_addr = 32'h300; d_wr = 1'b0; d_wdata = '0; #1;
        check("t4_d_ready", 32'(d_req_ready_3), 32'd1);
        tick(); d_v = 1'b0; i_v = 1'b1; i_addr = 32'h10; #1;
        check("t4_addr_c1",    mem_addr_3,          32'h300);
        check("t4_i_ready_c1", 32'(i_req_ready_3),  32'd0);
        check("t4_wr_ena_c1",  32'(mem_wr_ena_3),   32'd0);
        check("t4_wr_data_c1", mem_wr_data_3,       32'd0);
        tick();
        check("t4_addr_c2",    mem_addr_3,          32'h300);
        check("t4_i_ready_c2", 32'(i_req_ready_3),  32'd0);
        tick();
        check("t4_addr_c3",    mem_addr_3,          32'h300);
        check("t4_i_ready_c3", 32'(i_req_ready_3),  32'd0);
        check("t4_rsp_early",  32'(d_rsp_valid_3),  32'd0);
        tick();
        check("t4_d_rsp_valid", 32'(d_rsp_valid_3), 32'd1);
        check("t4_d_rsp_data",  d_rsp_data_3,        32'h303);
        check("t4_d_rsp_err",   32'(d_rsp_err_3),    32'd0);
        check("t4_i_ready_c4",  32'(i_req_ready_3),  32'd1);
        check("t4_addr_c4",     mem_addr_3,          32'd0);
        tick(); i_v = 1'b0;
        repeat (3) tick();
        check("t4_i_rsp_valid", 32'(i_rsp_valid_3), 32'd1);
        check("t4_i_rsp_data",  i_rsp_data_3,        32'h13);
        check("t4_i_rsp_err",   32'(i_rsp_err_3),    32'd0);
        tick(); sel3 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
